// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// memory geometry and the image checksum rule, which the host-side image
// builder also uses.
package imem_loader_pkg;

  localparam int MEM_BYTES_DEF = 1024;
  localparam int WORD_BYTES    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Running checksum: plain byte sum modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

  // An image is good when the data sum plus the trailing checksum byte wraps to zero.
  function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] data);
    return (csum_add(sum, data) == 8'd0);
  endfunction

  // States in which the loader is actively consuming the byte stream.
  function automatic logic state_busy(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted data bytes big-endian into 32-bit words and issues one
// registered instruction-memory write per completed word.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  logic [23:0]       shift_r;
  logic [1:0]        idx_r;
  logic [ADDR_W-1:0] addr_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              word_done_s;
  logic [31:0]       word_s;

  // The earliest byte of a group has been shifted up to [31:24] by the time the fourth arrives.
  assign word_s      = {shift_r, byte_data};
  assign word_done_s = byte_valid & (idx_r == 2'd3);

  // Byte shifting, word-address tracking and the registered write port.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shift_r     <= 24'd0;
      idx_r       <= 2'd0;
      addr_r      <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'd0;
    end else if (clear) begin
      shift_r     <= 24'd0;
      idx_r       <= 2'd0;
      addr_r      <= '0;
      mem_we_r    <= 1'b0;
    end else begin
      mem_we_r <= word_done_s;
      if (byte_valid) begin
        shift_r <= word_s[23:0];
        idx_r   <= idx_r + 2'd1;
      end
      if (word_done_s) begin
        mem_addr_r  <= addr_r;
        mem_wdata_r <= word_s;
        addr_r      <= addr_r + ADDR_W'(WORD_BYTES);
      end
    end
  end

  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, checksummed image
// over a byte stream, writes it word by word and holds the CPU until a
// verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] len_r;
  logic [15:0] cnt_r;
  logic [7:0]  sum_r;
  logic        in_ready_r;
  logic        busy_r;
  logic        cpu_hold_r;
  logic        done_r;
  logic        error_r;
  logic        fire_s;
  logic        load_start_s;
  logic [15:0] len_full_s;
  logic        len_bad_s;

  assign fire_s     = in_valid & in_ready_r;
  assign len_full_s = {len_r[15:8], in_data};
  assign len_bad_s  = (len_full_s == 16'd0) || (len_full_s[1:0] != 2'b00) ||
                      (32'(len_full_s) > 32'(MEM_BYTES));
  // A fresh load begins whenever we step into LEN_HI from a non-LEN_HI state.
  assign load_start_s = (state_next_s == ST_LEN_HI) && (state_r != ST_LEN_HI);

  // Next-state logic for the load sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   if (start) state_next_s = ST_LEN_HI; else state_next_s = ST_IDLE;
      ST_LEN_HI: if (fire_s) state_next_s = ST_LEN_LO; else state_next_s = ST_LEN_HI;
      ST_LEN_LO: begin
        if (fire_s) begin
          if (len_bad_s) state_next_s = ST_ERROR; else state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_LEN_LO;
        end
      end
      ST_DATA: begin
        if (fire_s && (cnt_r == (len_r - 16'd1))) state_next_s = ST_CHK;
        else state_next_s = ST_DATA;
      end
      ST_CHK: begin
        if (fire_s) begin
          if (csum_ok(sum_r, in_data)) state_next_s = ST_DONE; else state_next_s = ST_ERROR;
        end else begin
          state_next_s = ST_CHK;
        end
      end
      ST_DONE:   if (start) state_next_s = ST_LEN_HI; else state_next_s = ST_IDLE;
      ST_ERROR:  if (start) state_next_s = ST_LEN_HI; else state_next_s = ST_ERROR;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State register plus outputs registered from the next state so they align with it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      cpu_hold_r <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= state_busy(state_next_s);
      busy_r     <= state_busy(state_next_s);
      cpu_hold_r <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
      done_r     <= (state_next_s == ST_DONE);
      error_r    <= (state_next_s == ST_ERROR);
    end
  end

  // Length capture, data byte counting and checksum accumulation.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      len_r <= 16'd0;
      cnt_r <= 16'd0;
      sum_r <= 8'd0;
    end else if (load_start_s) begin
      len_r <= 16'd0;
      cnt_r <= 16'd0;
      sum_r <= 8'd0;
    end else if (fire_s) begin
      case (state_r)
        ST_LEN_HI: len_r[15:8] <= in_data;
        ST_LEN_LO: len_r[7:0]  <= in_data;
        ST_DATA: begin
          cnt_r <= cnt_r + 16'd1;
          sum_r <= csum_add(sum_r, in_data);
        end
        default: ;
      endcase
    end
  end

  imem_word_packer #(.ADDR_W(ADDR_W)) u_packer (
    .CLK        (CLK),
    .RESET      (RESET),
    .clear      (load_start_s),
    .byte_valid (fire_s && (state_r == ST_DATA)),
    .byte_data  (in_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign cpu_hold = cpu_hold_r;
  assign done     = done_r;
  assign error    = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images from the test plan
// plus randomized images, all checked against a byte-level reference model.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int vec_cnt = 0;
  int err_cnt = 0;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0;
  logic [7:0]  img_q[$];

  imem_loader dut (
    .CLK(CLK), .RESET(RESET), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error)
  );

  initial forever #5 CLK = ~CLK;

  // Record every memory write and done pulse, sampled mid-cycle.
  always @(negedge CLK) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte after `gap` idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    for (int i = 0; i < g; i++) @(negedge CLK);
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      ok = in_ready;
      @(posedge CLK);
      @(negedge CLK);
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) check_val("accept_timeout", 64'd0, 64'd1);
  endtask

  // Drive one image (length, img_q bytes, checksum) and compare with the model.
  task automatic run_image(input string tag, input int len, input logic [7:0] chk,
                           input int gap, input bit hold_start);
    int  mark_w, mark_d, nwords, got_words, sum;
    bit  legal, pass;
    mark_w = wr_addr_q.size();
    mark_d = done_cnt;
    legal  = (len != 0) && (len % 4 == 0) && (len <= 1024);
    sum = 0;
    if (legal) for (int i = 0; i < len; i++) sum += int'(img_q[i]);
    pass   = legal && (((sum + int'(chk)) % 256) == 0);
    nwords = pass || legal ? len / 4 : 0;

    check_val({tag, ":idle_ready"}, 64'(in_ready), 64'd0);
    start = 1'b1;
    @(posedge CLK);
    #1 if (!hold_start) start = 1'b0;
    @(negedge CLK);
    check_val({tag, ":start_ready"}, 64'(in_ready), 64'd1);
    check_val({tag, ":start_hold"}, 64'(cpu_hold), 64'd1);
    check_val({tag, ":start_err_clr"}, 64'(error), 64'd0);

    send_byte(8'((len >> 8) & 255), gap);
    send_byte(8'(len & 255), gap);
    if (!legal) begin
      start = 1'b0;
      check_val({tag, ":badlen_err"}, 64'(error), 64'd1);
      check_val({tag, ":badlen_hold"}, 64'(cpu_hold), 64'd1);
      check_val({tag, ":badlen_busy"}, 64'(busy), 64'd0);
      check_val({tag, ":badlen_nowr"}, 64'(wr_addr_q.size() - mark_w), 64'd0);
      return;
    end
    for (int i = 0; i < len; i++) send_byte(img_q[i], gap);
    start = 1'b0;
    send_byte(chk, gap);
    check_val({tag, ":done"}, 64'(done), 64'(pass));
    check_val({tag, ":error"}, 64'(error), 64'(!pass));
    check_val({tag, ":hold_end"}, 64'(cpu_hold), 64'(!pass));
    check_val({tag, ":done_ready"}, 64'(in_ready), 64'd0);
    @(negedge CLK);
    check_val({tag, ":done_pulse"}, 64'(done), 64'd0);
    check_val({tag, ":err_sticky"}, 64'(error), 64'(!pass));
    check_val({tag, ":done_cnt"}, 64'(done_cnt - mark_d), 64'(pass));
    got_words = wr_addr_q.size() - mark_w;
    check_val({tag, ":nwrites"}, 64'(got_words), 64'(nwords));
    for (int w = 0; w < nwords && w < got_words; w++) begin
      check_val({tag, ":wr_addr"}, 64'(wr_addr_q[mark_w + w]), 64'(4 * w));
      check_val({tag, ":wr_data"}, 64'(wr_data_q[mark_w + w]),
                64'({img_q[4*w], img_q[4*w+1], img_q[4*w+2], img_q[4*w+3]}));
    end
  endtask

  task automatic load_nominal();
    img_q = {8'h00, 8'h01, 8'h10, 8'h20, 8'h00, 8'h64, 8'h28, 8'h24};
  endtask

  initial begin
    int mark_w, len, sum;
    logic [7:0] chk;
    RESET = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(negedge CLK);
    check_val("rst_ready", 64'(in_ready), 64'd0);
    check_val("rst_we", 64'(mem_we), 64'd0);
    check_val("rst_addr", 64'(mem_addr), 64'd0);
    check_val("rst_wdata", 64'(mem_wdata), 64'd0);
    check_val("rst_hold", 64'(cpu_hold), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_error", 64'(error), 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    load_nominal();
    run_image("nominal", 8, 8'h1F, 0, 1'b0);
    run_image("len6", 6, 8'h00, 0, 1'b0);
    run_image("len0", 0, 8'h00, 0, 1'b0);
    run_image("len1028", 1028, 8'h00, 0, 1'b0);
    load_nominal();
    run_image("badchk", 8, 8'h20, 0, 1'b0);
    run_image("recover", 8, 8'h1F, 0, 1'b0);
    run_image("bpress", 8, 8'h1F, 2, 1'b0);

    // Reset in the middle of the data phase.
    mark_w = wr_addr_q.size();
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    @(negedge CLK);
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    for (int i = 0; i < 6; i++) send_byte(img_q[i], 0);
    #2 RESET = 1'b1;
    #1;
    check_val("mid_rst_ready", 64'(in_ready), 64'd0);
    check_val("mid_rst_addr", 64'(mem_addr), 64'd0);
    check_val("mid_rst_wdata", 64'(mem_wdata), 64'd0);
    check_val("mid_rst_hold", 64'(cpu_hold), 64'd0);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_error", 64'(error), 64'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("mid_rst_writes", 64'(wr_addr_q.size() - mark_w), 64'd1);
    run_image("after_rst", 8, 8'h1F, 0, 1'b0);

    // Full memory with start held high during the load.
    img_q.delete();
    sum = 0;
    for (int i = 0; i < 1024; i++) begin
      img_q.push_back(8'($urandom_range(0, 255)));
      sum += int'(img_q[i]);
    end
    chk = 8'((256 - (sum % 256)) % 256);
    run_image("fullmem", 1024, chk, 0, 1'b1);
    check_val("fullmem_last_addr", 64'(wr_addr_q[wr_addr_q.size() - 1]), 64'd1020);

    // Randomized images: lengths, payloads, checksums and stream gaps.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 4) == 0) len = int'($urandom_range(1, 2000)) | 1;
      else len = 4 * int'($urandom_range(1, 16));
      img_q.delete();
      sum = 0;
      for (int i = 0; i < len && i < 1024; i++) begin
        img_q.push_back(8'($urandom_range(0, 255)));
        sum += int'(img_q[i]);
      end
      chk = 8'((256 - (sum % 256)) % 256);
      if ($urandom_range(0, 2) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      run_image("random", len, chk, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
